// File: rtl/bbox_pkg.sv
// bbox_pkg: shared geometry constants, beat types and scan states for the bounding-box scan path
package bbox_pkg;
  localparam int IMG_W = 768;
  localparam int IMG_H = 512;
  localparam int ADDR_W = 19;
  localparam int PIX_W = 24;
  localparam int TAG_XW = $clog2(IMG_W);
  localparam int TAG_YW = $clog2(IMG_H);
  typedef logic [PIX_W-1:0] pixel_t;
  typedef struct packed {
    logic [TAG_XW-1:0] x;
    logic [TAG_YW-1:0] y;
    logic last;
  } tag_t;
  typedef struct packed {
    pixel_t pix;
    tag_t tag;
  } beat_t;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scan_state_t;
endpackage

// File: rtl/bbox_scan_sequencer_if.sv
// bbox_scan_sequencer_if: frame control, image RAM read port and tagged pixel stream
interface bbox_scan_sequencer_if #(
  parameter int IMG_W = bbox_pkg::IMG_W,
  parameter int IMG_H = bbox_pkg::IMG_H,
  parameter int ADDR_W = bbox_pkg::ADDR_W
);
  import bbox_pkg::*;
  logic start;
  logic busy;
  logic done;
  logic ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  pixel_t ram_q;
  logic pix_valid;
  logic pix_ready;
  pixel_t pix_data;
  logic [$clog2(IMG_W)-1:0] pix_x;
  logic [$clog2(IMG_H)-1:0] pix_y;
  logic pix_last;
  modport master (
    input start, ram_q, pix_ready,
    output busy, done, ram_rd_en, ram_addr, pix_valid, pix_data, pix_x, pix_y, pix_last
  );
  modport slave (
    output start, ram_q, pix_ready,
    input busy, done, ram_rd_en, ram_addr, pix_valid, pix_data, pix_x, pix_y, pix_last
  );
endinterface

// File: rtl/bbox_tag_fifo.sv
// bbox_tag_fifo: register FIFO of pixel+tag beats whose head entry feeds the stream directly
module bbox_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  bbox_pkg::beat_t din,
  input  logic pop,
  output bbox_pkg::beat_t head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import bbox_pkg::*;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  beat_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  // storage needs no reset; only the pointers define what is valid
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // pointers and occupancy; push and pop together leave occupancy unchanged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PW'(DEPTH-1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PW'(DEPTH-1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  // the read credit upstream must keep a full FIFO from taking an unmatched push
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && count == CW'(DEPTH)));
endmodule

// File: rtl/bbox_scan_sequencer.sv
// bbox_scan_sequencer: raster-scan image RAM reader delivering an (x, y, last)-tagged pixel stream
module bbox_scan_sequencer #(
  parameter int IMG_W = bbox_pkg::IMG_W,
  parameter int IMG_H = bbox_pkg::IMG_H,
  parameter int ADDR_W = bbox_pkg::ADDR_W,
  parameter int RD_LAT = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic CLOCK_50,
  input logic rst_n,
  bbox_scan_sequencer_if.master bus
);
  import bbox_pkg::*;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  scan_state_t state, state_nx;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ADDR_W-1:0] addr;
  logic [RD_LAT-1:0] pipe_v;
  tag_t pipe_tag [RD_LAT];
  logic [CW-1:0] count;
  beat_t head;
  logic credit, issue, at_end, row_end, accept, valid, fire;
  assign credit = $countones(pipe_v) + int'(count) < FIFO_DEPTH;
  assign issue = state == SCAN && credit;
  assign row_end = x == XW'(IMG_W-1);
  assign at_end = row_end && y == YW'(IMG_H-1);
  assign accept = (state == IDLE || state == DONE) && bus.start;
  assign valid = count != '0;
  assign fire = valid && bus.pix_ready;
  assign bus.busy = state == SCAN || state == DRAIN;
  assign bus.done = state == DONE;
  assign bus.ram_rd_en = issue;
  assign bus.ram_addr = addr;
  assign bus.pix_valid = valid;
  assign bus.pix_data = valid ? head.pix : '0;
  assign bus.pix_x = valid ? head.tag.x[XW-1:0] : '0;
  assign bus.pix_y = valid ? head.tag.y[YW-1:0] : '0;
  assign bus.pix_last = valid && head.tag.last;
  // state register
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: starts only count when idle or done; drain ends after the last beat leaves
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nx = SCAN;
      SCAN: if (issue && at_end) state_nx = DRAIN;
      DRAIN: if (fire && bus.pix_last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // scan position and a running address that advance once per issued read
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      addr <= '0;
    end else if (accept) begin
      x <= '0;
      y <= '0;
      addr <= '0;
    end else if (issue) begin
      x <= row_end ? '0 : x + 1'b1;
      y <= row_end ? y + 1'b1 : y;
      addr <= addr + 1'b1;
    end
  // tag pipe matches the RAM latency so each returning word lands beside its own position
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_v[0] <= issue;
      pipe_tag[0] <= '{x: TAG_XW'(x), y: TAG_YW'(y), last: at_end};
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  bbox_tag_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLOCK_50),
    .rst_n(rst_n),
    .push(pipe_v[RD_LAT-1]),
    .din('{pix: bus.ram_q, tag: pipe_tag[RD_LAT-1]}),
    .pop(fire),
    .head(head),
    .count(count)
  );
endmodule

// File: tb/tb_bbox_scan_sequencer.sv
// tb_bbox_scan_sequencer: randomized bench comparing two scan configurations against a raster-order model
module tb_bbox_scan_sequencer;
  import bbox_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start = '0;
  logic [1:0] ready = '0;
  logic [1:0] valid, busy, done, rd_en, any_out;
  pixel_t mem [2][256];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W = g ? 8 : 4;
    localparam int H = g ? 2 : 3;
    localparam int LAT = g ? 2 : 1;
    localparam int N = W * H;
    bbox_scan_sequencer_if #(.IMG_W(W), .IMG_H(H), .ADDR_W(8)) bus ();
    bbox_scan_sequencer #(
      .IMG_W(W), .IMG_H(H), .ADDR_W(8), .RD_LAT(LAT), .FIFO_DEPTH(g ? 3 : 4)
    ) dut (
      .CLOCK_50(clk),
      .rst_n(rst_n),
      .bus(bus)
    );
    pixel_t q [LAT];
    int k = 0;
    logic stall = 1'b0;
    logic done_q = 1'b0;
    logic [63:0] held, cur, exp;
    assign bus.start = start[g];
    assign bus.pix_ready = ready[g];
    assign bus.ram_q = q[LAT-1];
    assign valid[g] = bus.pix_valid;
    assign busy[g] = bus.busy;
    assign done[g] = bus.done;
    assign rd_en[g] = bus.ram_rd_en;
    assign any_out[g] = |{bus.busy, bus.done, bus.ram_rd_en, bus.ram_addr, bus.pix_valid,
                          bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last};
    always @(posedge clk) begin
      q[0] <= bus.ram_rd_en ? mem[g][bus.ram_addr] : 24'hbad000;
      for (int i = 1; i < LAT; i++) q[i] <= q[i-1];
    end
    always @(negedge clk) begin
      cur = {15'd0, 1'b1, 7'd0, bus.pix_last, 8'(bus.pix_y), 8'(bus.pix_x), bus.pix_data};
      exp = {15'd0, 1'(k < N), 7'd0, 1'(k == N - 1), 8'(k / W), 8'(k % W), mem[g][k % 256]};
      if (!rst_n) begin
        k = 0;
        stall = 1'b0;
        done_q = 1'b0;
      end else begin
        if (stall) check("hold", {bus.pix_valid, cur[62:0]}, {1'b1, held[62:0]});
        if (bus.pix_valid && bus.pix_ready) begin
          check("beat", cur, exp);
          k++;
        end
        stall = bus.pix_valid && !bus.pix_ready;
        held = cur;
        if (bus.done && !done_q) check("frame_beats", 64'(k), 64'(N));
        done_q = bus.done;
        if (start[g] && !bus.busy) k = 0;
      end
    end
  end

  // mode 0: ready high; 1: stall window then toggle; 2: random ready; 3: ready high plus starts while busy
  task automatic run_frame(input int g, input int mode, input int limit, input int abort_at,
                           output int first_rd, output int first_v, output int done_c, output int reads13);
    int beats = 0;
    first_rd = 0;
    first_v = 0;
    done_c = 0;
    reads13 = 0;
    start[g] = 1'b1;
    @(posedge clk);
    #1 start[g] = 1'b0;
    for (int c = 1; c <= limit && done_c == 0; c++) begin
      ready[g] = mode == 1 ? (c < 4 ? 1'b1 : c <= 13 ? 1'b0 : 1'(c % 2)) :
                 mode == 2 ? 1'($urandom_range(1)) : 1'b1;
      start[g] = mode == 3 && busy[g] && c % 3 == 0;
      @(negedge clk);
      if (c == 1) check("done_clear", 64'(done[g]), 64'd0);
      if (rd_en[g]) begin
        if (first_rd == 0) first_rd = c;
        if (c <= 13) reads13++;
      end
      if (valid[g] && first_v == 0) first_v = c;
      if (valid[g] && ready[g]) beats++;
      if (done[g]) done_c = c;
      @(posedge clk);
      #1;
      if (abort_at != 0 && beats == abort_at) begin
        start[g] = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("async_clear", 64'(any_out), 64'd0);
        return;
      end
    end
    start[g] = 1'b0;
    if (abort_at == 0) check("done_seen", 64'(done_c != 0), 64'd1);
  endtask

  initial begin
    int frd, fv, dc, r13;
    for (int a = 0; a < 256; a++) begin
      mem[0][a] = pixel_t'(a + 'h100);
      mem[1][a] = pixel_t'($urandom);
    end
    for (int c = 0; c < 6; c++) begin
      start = 2'($urandom);
      ready = 2'($urandom);
      @(negedge clk);
      check("reset_outs", 64'(any_out), 64'd0);
    end
    start = '0;
    ready = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(0, 0, 60, 0, frd, fv, dc, r13);
    check("first_rd", 64'(frd), 64'd1);
    check("first_valid", 64'(fv), 64'd3);
    check("done_cycle", 64'(dc), 64'd15);
    check("busy_in_done", 64'(busy[0]), 64'd0);
    run_frame(0, 1, 200, 0, frd, fv, dc, r13);
    check("reads_stalled", 64'(r13), 64'd5);
    run_frame(0, 3, 200, 0, frd, fv, dc, r13);
    check("inject_done", 64'(dc), 64'd15);
    run_frame(0, 0, 60, 0, frd, fv, dc, r13);
    check("repeat_done", 64'(dc), 64'd15);
    run_frame(0, 0, 60, 5, frd, fv, dc, r13);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(0, 0, 60, 0, frd, fv, dc, r13);
    check("post_reset_valid", 64'(fv), 64'd3);
    check("post_reset_done", 64'(dc), 64'd15);
    for (int f = 0; f < 3; f++) run_frame(1, 2, 2000, 0, frd, fv, dc, r13);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bbox_scan_sequencer.md
Name: bbox_scan_sequencer

Overview:
Raster-scan sequencer that walks the image RAM of the bounding-box top, one pixel address per cycle, and absorbs the RAM read latency. It delivers a valid/ready pixel stream tagged with (x, y) and a last flag to the bounding-box accumulator. A start/busy/done handshake lets the top, or the bench polling done, run one frame per start.

Parameters:
IMG_W, 768, image width in pixels
IMG_H, 512, image height in pixels
ADDR_W, 19, RAM address width (must satisfy 2^ADDR_W >= IMG_W*IMG_H)
PIX_W, 24, pixel width (RGB888)
RD_LAT, 1, RAM read latency in cycles (rd_en to ram_q valid), >= 1
FIFO_DEPTH, 4, output buffer entries, >= RD_LAT+1

Ports:
CLOCK_50  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset (KEY[3] at top level)
start  in  1  one-cycle request to scan a frame
busy  out  1  high in SCAN and DRAIN
done  out  1  high in DONE; held until next accepted start
ram_rd_en  out  1  read strobe to image RAM
ram_addr  out  ADDR_W  read address, y*IMG_W+x
ram_q  in  PIX_W  RAM read data, valid RD_LAT cycles after ram_rd_en
pix_valid  out  1  stream beat valid
pix_ready  in  1  downstream accepts beat
pix_data  out  PIX_W  pixel value
pix_x  out  clog2(IMG_W)  column of beat
pix_y  out  clog2(IMG_H)  row of beat
pix_last  out  1  beat is pixel (IMG_W-1, IMG_H-1)

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, ram_rd_en, pix_valid, pix_last = 0; ram_addr, pix_x, pix_y, pix_data = 0; counters cleared, FIFO emptied, in-flight reads discarded.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: start=1 -> SCAN; x=y=0, addr=0.
- SCAN: ram_rd_en=1 in each cycle where credit exists. Credit condition: outstanding reads + FIFO occupancy < FIFO_DEPTH.
  - On issue: x++; at x==IMG_W-1 wrap x=0, y++. addr increments by 1 (running counter, no multiplier).
  - Issuing (IMG_W-1, IMG_H-1) -> DRAIN.
- Tags: (x, y, last) travel in a RD_LAT-deep shift pipe alongside each read. ram_q and its tag are written into the FIFO in the same cycle the data is valid. The FIFO never overflows, by the credit rule.
- Output: pix_* driven from FIFO head, registered. A beat transfers on pix_valid & pix_ready. pix_valid/pix_data/tags are held stable while pix_valid=1 & pix_ready=0.
- DRAIN: no reads issued. Go to DONE on the cycle after the handshake of the pix_last beat.
- DONE: done=1, busy=0. start=1 -> SCAN and clears done the same cycle.
- start in SCAN or DRAIN is ignored (no restart, no queuing).
- Latency: start accepted at edge 0, first ram_rd_en in cycle 1, first pix_valid in cycle RD_LAT+2. With pix_ready held 1, throughput is 1 beat/cycle and the frame completes in IMG_W*IMG_H + RD_LAT + 2 cycles from start to done.
- Simultaneous FIFO write and read at full occupancy is legal; occupancy is unchanged.
- Exactly IMG_W*IMG_H beats per frame, raster order, no duplicates or drops under any pix_ready pattern.

Decomposition:
- Package bbox_pkg: IMG_W, IMG_H, ADDR_W, PIX_W constants; pixel_t; tag struct {x, y, last}; state enum scan_state_t.
- One sub-module: bbox_tag_fifo. It is a synchronous FIFO of {pixel_t, tag}, FIFO_DEPTH entries, with occupancy output used for credit, and uses async active-low reset.
- The sequencer FSM, counters and tag pipe live in the top of this block.

Test Plan:
- Reset: hold rst_n=0 with random start/pix_ready -> all outputs 0. Assert rst_n=0 asynchronously mid-cycle -> outputs clear before next edge.
- IMG_W=4, IMG_H=3, RD_LAT=1, RAM preloaded mem[a]=a+0x100, pix_ready=1, start pulse -> 12 beats (x,y)=(0,0)..(3,2), data 0x100..0x10B, pix_last only on beat 12, first pix_valid cycle 3, done=1 at cycle 15.
- Backpressure, same image: pix_ready=0 for cycles 4-13, then toggling every cycle -> ram_rd_en drops once outstanding+occupancy=4. Scoreboard shows 12 beats, in order, data stable while stalled.
- start pulses during SCAN and DRAIN -> ignored, still exactly 12 beats. start during DONE -> done clears next cycle and a second identical frame follows.
- Reset mid-frame after beat 5 (x=0,y=1), release, start -> new frame begins at (0,0) data 0x100, no stale FIFO beats appear.
- RD_LAT=2, FIFO_DEPTH=3, IMG_W=8, IMG_H=2, random pix_ready (50%) -> 16 beats correct, no FIFO overflow assertion fires, done only after last handshake.
